// File: rtl/rect_layer_compositor.sv
// rect_layer_compositor
//   Composites up to NUM_LAYERS rectangles over an optional grid and a
//   background colour, one pixel per clock, with 2-cycle latency and no stalls.
//   Rectangle geometry is double-buffered: shadow registers are written by
//   software and copied to the active set on frame_start.
// Ports:
//   clk, rst_n                  pixel clock, async active-low reset
//   cfg_we/cfg_layer/cfg_*      shadow register write for one layer
//   frame_start                 commit shadow -> active
//   commit_pending              shadow differs from active
//   in_valid/pos_x/pos_y        pixel coordinate stream
//   back_color/grid_*           background and grid overlay controls
//   out_valid/rgb_out/hit/hit_layer  composited result, 2 cycles later
module rect_layer_compositor #(
  parameter int NUM_LAYERS = 4,
  parameter int COORD_W    = 11,
  parameter int COLOR_W    = 24,
  parameter int GRID_PITCH = 80,
  parameter int LAYER_W    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [LAYER_W-1:0] cfg_layer,
  input  logic [COORD_W-1:0] cfg_x,
  input  logic [COORD_W-1:0] cfg_y,
  input  logic [COORD_W-1:0] cfg_w,
  input  logic [COORD_W-1:0] cfg_h,
  input  logic [COLOR_W-1:0] cfg_color,
  input  logic               cfg_en,
  input  logic               frame_start,
  output logic               commit_pending,
  input  logic               in_valid,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic [COLOR_W-1:0] back_color,
  input  logic               grid_en,
  input  logic [COLOR_W-1:0] grid_color,
  output logic               out_valid,
  output logic [COLOR_W-1:0] rgb_out,
  output logic               hit,
  output logic [LAYER_W-1:0] hit_layer
);

  typedef struct packed {
    logic               en;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
    logic [COLOR_W-1:0] color;
  } layer_t;

  localparam logic [LAYER_W:0]   NUM_L = (LAYER_W+1)'(NUM_LAYERS);
  localparam logic [COORD_W-1:0] PITCH = COORD_W'(GRID_PITCH);

  layer_t shadow_q   [NUM_LAYERS];
  layer_t active_q   [NUM_LAYERS];
  layer_t shadow_nxt [NUM_LAYERS];
  logic   cfg_ok;

  assign cfg_ok = ({1'b0, cfg_layer} < NUM_L);

  // Next shadow state feeds both the shadow and the active set, so a write
  // coinciding with frame_start is committed in the same edge.
  always_comb begin
    shadow_nxt = shadow_q;
    if (cfg_we && cfg_ok) begin
      shadow_nxt[cfg_layer] = '{en: cfg_en, x: cfg_x, y: cfg_y, w: cfg_w,
                                h: cfg_h, color: cfg_color};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      commit_pending <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        shadow_q[i] <= shadow_nxt[i];
        if (frame_start) active_q[i] <= shadow_nxt[i];
      end
      if (frame_start)               commit_pending <= 1'b0;
      else if (cfg_we && cfg_ok)     commit_pending <= 1'b1;
    end
  end

  // Stage 1: hit test against the current active set. Right-hand edges use
  // one extra bit so x+w never wraps.
  logic [NUM_LAYERS-1:0] hit_vec;
  logic                  grid_hit;

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      hit_vec[i] = active_q[i].en && (|active_q[i].w) && (|active_q[i].h)
                && (pos_x >= active_q[i].x)
                && ({1'b0, pos_x} < ({1'b0, active_q[i].x} + {1'b0, active_q[i].w}))
                && (pos_y >= active_q[i].y)
                && ({1'b0, pos_y} < ({1'b0, active_q[i].y} + {1'b0, active_q[i].h}));
    end
    grid_hit = grid_en && (((pos_x % PITCH) == '0) || ((pos_y % PITCH) == '0));
  end

  logic                  s1_vld;
  logic [NUM_LAYERS-1:0] s1_hit;
  logic                  s1_grid;
  logic [COLOR_W-1:0]    s1_back;
  logic [COLOR_W-1:0]    s1_gridc;
  logic [COLOR_W-1:0]    s1_color [NUM_LAYERS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      s1_hit   <= '0;
      s1_grid  <= 1'b0;
      s1_back  <= '0;
      s1_gridc <= '0;
      for (int i = 0; i < NUM_LAYERS; i++) s1_color[i] <= '0;
    end else begin
      s1_vld   <= in_valid;
      s1_hit   <= hit_vec;
      s1_grid  <= grid_hit;
      s1_back  <= back_color;
      s1_gridc <= grid_color;
      // Colour captured with the geometry so a commit cannot split them.
      for (int i = 0; i < NUM_LAYERS; i++) s1_color[i] <= active_q[i].color;
    end
  end

  // Stage 2: fixed-priority encode, lowest index wins.
  logic [LAYER_W-1:0] sel;
  logic               any_hit;

  always_comb begin
    sel     = '0;
    any_hit = |s1_hit;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (s1_hit[i]) sel = LAYER_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      rgb_out   <= '0;
      hit       <= 1'b0;
      hit_layer <= '0;
    end else begin
      out_valid <= s1_vld;
      if (s1_vld) begin
        hit       <= any_hit;
        hit_layer <= sel;
        rgb_out   <= any_hit ? s1_color[sel] : (s1_grid ? s1_gridc : s1_back);
      end else begin
        hit       <= 1'b0;
        hit_layer <= '0;
        rgb_out   <= '0;
      end
    end
  end

endmodule
